// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic [2:0] OFS_TXDATA = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd4;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Byte-wide synchronous FIFO; a push while full and a pop while empty
// are both ignored.
module sync_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q];
    assign count   = cnt_q;

    always_comb begin
        wptr_d = wptr_q + AW'(do_push);
        rptr_d = rptr_q + AW'(do_pop);
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (do_push) begin
                mem_q[wptr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window,
// TX FIFO and bit serialiser.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = $clog2(CLK_DIV);

    state_e          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;

    logic            is_status;
    logic            push_req;
    logic            clr_ovf;
    logic            pop;
    logic            bit_tick;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     status;
    logic            unused_bits;

    assign unused_bits = ^{wd[31:8], addr[1:0]};

    assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
    assign is_status = ({addr[2], 2'b00} == OFS_STATUS);
    assign push_req  = we && sel && !is_status;
    assign clr_ovf   = we && sel && is_status && wd[ST_OVF];
    assign bit_tick  = (cnt_q == DW'(CLK_DIV - 1));

    sync_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push_req),
        .din  (wd[7:0]),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_comb begin
        status               = '0;
        status[ST_BUSY]      = busy_q;
        status[ST_FULL]      = fifo_full;
        status[ST_EMPTY]     = fifo_empty;
        status[ST_OVF]       = ovf_q;
        status[ST_CNT_LSB+:8] = 8'(fifo_count);
        rd = '0;
        if (sel && is_status) begin
            rd = status;
        end
    end

    // A dropped push in the same cycle as a clear leaves overflow set.
    always_comb begin
        ovf_d = ovf_q;
        if (push_req && fifo_full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_tick ? '0 : cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        // Outputs are registered, so derive them from the next state.
        busy_d = (state_d != IDLE);
        tx_d   = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

    localparam int CLK_DIV = 4;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic        tx;
    logic        busy;

    int n_chk;
    int n_fail;

    mmio_uart_tx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(4),
        .BASE_ADDR (32'h0000_1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .addr(addr),
        .wd  (wd),
        .rd  (rd),
        .sel (sel),
        .tx  (tx),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent line receiver: samples each bit one cycle into its slot.
    logic [9:0] rxq[$];
    logic [9:0] rx_sh;
    bit         rx_on;
    int         rx_cyc;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_on  = 1'b0;
            rx_cyc = 0;
            rxq.delete();
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on    = 1'b1;
                rx_sh    = '1;
                rx_sh[0] = tx;
                rx_cyc   = 1;
            end
        end else begin
            if (rx_cyc % CLK_DIV == 1) rx_sh[rx_cyc / CLK_DIV] = tx;
            if (rx_cyc == 9 * CLK_DIV + 1) rxq.push_back(rx_sh);
            if (rx_cyc == 10 * CLK_DIV - 1) rx_on = 1'b0;
            rx_cyc++;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_sel;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we   = 1'b1;
        addr = a;
        wd   = d;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        we   = 1'b0;
        addr = 32'h0;
        wd   = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] r,
                            output logic s);
        @(negedge clk);
        we   = 1'b0;
        addr = a;
        #1;
        r = rd;
        s = sel;
    endtask

    // Entered on the negedge showing the start bit's first cycle.
    task automatic capture_frame(input logic [7:0] d, input string nm);
        logic [9:0] fb;
        logic [9:0] got;
        int         bad_tx;
        int         bad_busy;
        fb       = {1'b1, d, 1'b0};
        got      = '0;
        bad_tx   = 0;
        bad_busy = 0;
        for (int k = 0; k < 10 * CLK_DIV; k++) begin
            if (k % CLK_DIV == 1) got[k / CLK_DIV] = tx;
            if (tx !== fb[k / CLK_DIV]) bad_tx++;
            if (busy !== 1'b1) bad_busy++;
            @(negedge clk);
        end
        check({nm, "_bits"}, 32'(got), 32'(fb));
        check({nm, "_tx_steady"}, bad_tx, 0);
        check({nm, "_busy"}, bad_busy, 0);
    endtask

    vec_t        vecs[11];
    logic [31:0] r;
    logic        s;
    int          t;
    int          lows;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        we     = 1'b0;
        addr   = 32'h0;
        wd     = 32'h0;

        vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0, 32'h0000_0004, 1'b1};
        vecs[1]  = '{1'b0, 32'h0000_1000, 32'h0, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_1006, 32'h0, 32'h0000_0004, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0FFC, 32'h0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_1008, 32'h0, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_2000, 32'hAB, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_1008, 32'hCD, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_1004, 32'h0, 32'h0000_0004, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_1004, 32'hFFFF_FFF7, 32'h0000_0004, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_1007, 32'h0, 32'h0000_0004, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_1003, 32'h0, 32'h0000_0000, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);

        // Decode and register reads while idle.
        foreach (vecs[i]) begin
            @(negedge clk);
            we   = vecs[i].we;
            addr = vecs[i].addr;
            wd   = vecs[i].wd;
            #1;
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
        end
        bus_idle();
        repeat (6) @(negedge clk);
        check("decode_no_frame", rxq.size(), 0);
        check("decode_idle_busy", busy, 0);

        // Single byte; upper data bits must be ignored.
        bus_write(32'h0000_1000, 32'hFFFF_FFA5);
        bus_idle();
        check("single_tx_hold", tx, 1);
        @(negedge clk);
        capture_frame(8'hA5, "single");
        check("single_busy_drop", busy, 0);
        check("single_tx_idle", tx, 1);

        // Two back-to-back frames.
        rxq.delete();
        bus_write(32'h0000_1000, 32'h55);
        bus_write(32'h0000_1000, 32'h0F);
        bus_idle();
        capture_frame(8'h55, "b2b_first");
        capture_frame(8'h0F, "b2b_second");
        check("b2b_busy_drop", busy, 0);
        check("b2b_rx_count", rxq.size(), 2);

        // Overflow with a frame in flight.
        rxq.delete();
        bus_write(32'h0000_1000, 32'h11);
        for (int b = 1; b <= 5; b++) bus_write(32'h0000_1000, 32'h20 + b);
        bus_idle();
        bus_read(32'h0000_1004, r, s);
        check("ovf_status", r, 32'h0000_040B);
        bus_write(32'h0000_1004, 32'h8);
        bus_idle();
        bus_read(32'h0000_1004, r, s);
        check("ovf_cleared", r, 32'h0000_0403);
        t = 0;
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("ovf_drain_in_time", t < 400, 1);
        check("ovf_frame_count", rxq.size(), 5);
        if (rxq.size() == 5) begin
            check("ovf_frame0", rxq[0], {1'b1, 8'h11, 1'b0});
            for (int b = 1; b <= 4; b++)
                check($sformatf("ovf_frame%0d", b), rxq[b],
                      {1'b1, 8'(8'h20 + b), 1'b0});
        end
        bus_read(32'h0000_1004, r, s);
        check("ovf_final_status", r, 32'h0000_0004);

        // Reset during DATA bit 3, with a second byte still queued.
        bus_write(32'h0000_1000, 32'h3C);
        bus_write(32'h0000_1000, 32'h77);
        bus_idle();
        repeat (4 * CLK_DIV + 1) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        check("midrst_bit3_before", tx, 1);
        addr = 32'h0000_1004;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx_async", tx, 1);
        check("midrst_busy_async", busy, 0);
        check("midrst_status", rd, 32'h0000_0004);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        addr = 32'h0;
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("midrst_no_residual", lows, 0);
        check("midrst_rx_empty", rxq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
